piso_tx: RTL and testbench



---
 rtl/piso_pkg.sv | 26 ++
 rtl/piso_tx.sv | 131 +++++++++++++
 tb/tb_piso_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and helpers for the piso_tx serial transmitter.
//               - piso_state_t : FSM state encoding (IDLE / SHIFT)
//               - cnt_width()  : bit-counter width for a given word width
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Narrowest counter width that is still at least one bit wide.
  localparam int unsigned c_MIN_CNT_W = 1;

  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < c_MIN_CNT_W) ? c_MIN_CNT_W : w;
  endfunction

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx
// Description : Parallel-in / serial-out transmitter. Accepts a WIDTH-bit
//               word on a valid/ready handshake and shifts it out one bit
//               per clock with a bit-valid and end-of-word marker. Gapless
//               back-to-back words are taken on the last-bit cycle.
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-high reset
//               p_in     - parallel word (sampled only on accept)
//               p_valid  - p_in holds a word to send
//               p_ready  - word can be accepted this cycle (combinational)
//               s_out    - serial data bit (registered)
//               s_valid  - s_out carries a word bit (registered)
//               s_last   - s_out is the final bit of the word (registered)
//               busy     - a word is being shifted
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

  localparam int unsigned        CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   c_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   c_PENULT = CNT_W'(WIDTH - 2);

  piso_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic             s_out_q, s_out_d;
  logic             s_valid_q, s_valid_d;
  logic             s_last_q,  s_last_d;

  logic             w_last;
  logic             w_accept;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_load_rem;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shift_rem;

  // The output bit is registered, so the shift register only holds the bits
  // not yet presented: on load the first bit goes straight to s_out and the
  // remainder is stored already shifted.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit = p_in[WIDTH-1];
      assign w_load_rem  = {p_in[WIDTH-2:0], 1'b0};
      assign w_next_bit  = sreg_q[WIDTH-1];
      assign w_shift_rem = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first_bit = p_in[0];
      assign w_load_rem  = {1'b0, p_in[WIDTH-1:1]};
      assign w_next_bit  = sreg_q[0];
      assign w_shift_rem = {1'b0, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  // cnt_q is the index of the bit currently on s_out.
  assign w_last   = (state_q == SHIFT) && (cnt_q == c_LAST);
  assign p_ready  = !rst && ((state_q == IDLE) || w_last);
  assign w_accept = p_valid && p_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    s_out_d   = 1'b0;
    s_valid_d = 1'b0;
    s_last_d  = 1'b0;

    if (w_accept) begin
      // Covers both the idle load and the gapless reload on the last bit.
      state_d   = SHIFT;
      cnt_d     = '0;
      sreg_d    = w_load_rem;
      s_out_d   = w_first_bit;
      s_valid_d = 1'b1;
      s_last_d  = 1'b0;
    end else if (state_q == SHIFT) begin
      if (w_last) begin
        state_d = IDLE;
        cnt_d   = '0;
        sreg_d  = '0;
      end else begin
        cnt_d     = cnt_q + CNT_W'(1);
        sreg_d    = w_shift_rem;
        s_out_d   = w_next_bit;
        s_valid_d = 1'b1;
        s_last_d  = (cnt_q == c_PENULT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      s_out_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      s_out_q   <= s_out_d;
      s_valid_q <= s_valid_d;
      s_last_q  <= s_last_d;
    end
  end

  assign s_out   = s_out_q;
  assign s_valid = s_valid_q;
  assign s_last  = s_last_q;
  assign busy    = (state_q == SHIFT);

endmodule : piso_tx
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx
// Description : Self-checking bench for piso_tx. Expected serial bits are
//               pushed to a queue when a word is handed over and popped as
//               the transmitter presents them. An MSB-first and an LSB-first
//               instance are exercised; a behavioural sipo closes the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] p_in;
  logic       p_valid;
  logic       p_ready, s_out, s_valid, s_last, busy;

  logic [3:0] l_p_in;
  logic       l_p_valid;
  logic       l_p_ready, l_s_out, l_s_valid, l_s_last, l_busy;

  logic [3:0] r_sipo;

  logic [1:0] exp_q[$];   // {s_out, s_last}
  logic [1:0] exp;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready),
    .s_out(s_out), .s_valid(s_valid), .s_last(s_last), .busy(busy)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .p_in(l_p_in), .p_valid(l_p_valid), .p_ready(l_p_ready),
    .s_out(l_s_out), .s_valid(l_s_valid), .s_last(l_s_last), .busy(l_busy)
  );

  // Behavioural sipo receiver: left-shift s_out on every s_valid cycle.
  always_ff @(posedge clk) begin
    if (rst)          r_sipo <= 4'b0;
    else if (s_valid) r_sipo <= {r_sipo[2:0], s_out};
  end

  task automatic push_word(input logic [3:0] w, input bit msb);
    for (int i = 0; i < 4; i++) begin
      logic b;
      b = msb ? w[3-i] : w[i];
      exp_q.push_back({b, (i == 3)});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; p_valid = 1'b0; p_in = 4'b0; l_p_valid = 1'b0; l_p_in = 4'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if ({s_out, s_valid, s_last, busy, p_ready} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_outputs cyc%0d: got %b want 00000", i, {s_out, s_valid, s_last, busy, p_ready});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (p_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: p_ready=%b busy=%b want 1 0", p_ready, busy);
    end
  endtask

  task automatic test_single();
    p_in = 4'b1010; p_valid = 1'b1;
    push_word(4'b1010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) p_valid = 1'b0;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      n_vec++;
      if ({s_valid, s_out, s_last} !== {1'b1, exp} || p_ready !== (i == 3) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL single bit%0d: valid/out/last=%b ready=%b busy=%b want 1%b ready=%b busy=1",
                 i, {s_valid, s_out, s_last}, p_ready, busy, exp, (i == 3));
      end
    end
    @(negedge clk);
    n_vec++;
    if ({s_valid, s_out, s_last, busy, p_ready} !== 5'b00001 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL single_idle: valid/out/last/busy/ready=%b want 00001", {s_valid, s_out, s_last, busy, p_ready});
    end
  endtask

  task automatic test_back_to_back();
    p_in = 4'b1100; p_valid = 1'b1;
    push_word(4'b1100, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      n_vec++;
      if ({s_valid, s_out, s_last} !== {1'b1, exp} || p_ready !== (i == 3 || i == 7)) begin
        n_err++;
        $display("FAIL b2b bit%0d: valid/out/last=%b ready=%b want 1%b ready=%b",
                 i, {s_valid, s_out, s_last}, p_ready, exp, (i == 3 || i == 7));
      end
      if (i == 0) p_in = 4'b0101;
      if (i == 3) push_word(4'b0101, 1'b1);
      if (i == 4) p_valid = 1'b0;
    end
    @(negedge clk);
    n_vec++;
    if ({s_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_idle: valid/busy=%b want 00", {s_valid, busy});
    end
  endtask

  task automatic test_mid_word_input();
    p_in = 4'b1001; p_valid = 1'b1;
    push_word(4'b1001, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      n_vec++;
      if ({s_valid, s_out, s_last} !== {1'b1, exp} || p_ready !== (i == 3 || i == 7)) begin
        n_err++;
        $display("FAIL midword bit%0d: valid/out/last=%b ready=%b want 1%b ready=%b",
                 i, {s_valid, s_out, s_last}, p_ready, exp, (i == 3 || i == 7));
      end
      if (i == 0) p_valid = 1'b0;
      if (i == 1) begin p_valid = 1'b1; p_in = 4'b0110; end
      if (i == 3) push_word(4'b0110, 1'b1);
      if (i == 4) p_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    p_in = 4'b1111; p_valid = 1'b1;
    push_word(4'b1111, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      p_valid = 1'b0;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      n_vec++;
      if ({s_valid, s_out, s_last} !== {1'b1, exp}) begin
        n_err++;
        $display("FAIL rstmid bit%0d: valid/out/last=%b want 1%b", i, {s_valid, s_out, s_last}, exp);
      end
    end
    // Reset during bit 2, with a competing word offered.
    rst = 1'b1; p_valid = 1'b1; p_in = 4'b0101;
    exp_q.delete();
    @(negedge clk);
    n_vec++;
    if ({s_valid, s_out, s_last, busy, p_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL rstmid_abort: valid/out/last/busy/ready=%b want 00000", {s_valid, s_out, s_last, busy, p_ready});
    end
    rst = 1'b0; p_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({s_valid, busy, p_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL rstmid_dropped: valid/busy/ready=%b want 001", {s_valid, busy, p_ready});
    end
    p_in = 4'b0011; p_valid = 1'b1;
    push_word(4'b0011, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p_valid = 1'b0;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      n_vec++;
      if ({s_valid, s_out, s_last} !== {1'b1, exp}) begin
        n_err++;
        $display("FAIL rstmid_next bit%0d: valid/out/last=%b want 1%b", i, {s_valid, s_out, s_last}, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_lsb_first();
    l_p_in = 4'b1010; l_p_valid = 1'b1;
    push_word(4'b1010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      l_p_valid = 1'b0;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'bxx;
      n_vec++;
      if ({l_s_valid, l_s_out, l_s_last} !== {1'b1, exp} || l_busy !== 1'b1) begin
        n_err++;
        $display("FAIL lsb bit%0d: valid/out/last=%b busy=%b want 1%b busy=1",
                 i, {l_s_valid, l_s_out, l_s_last}, l_busy, exp);
      end
    end
    @(negedge clk);
    n_vec++;
    if ({l_s_valid, l_s_out, l_busy, l_p_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL lsb_idle: valid/out/busy/ready=%b want 0001", {l_s_valid, l_s_out, l_busy, l_p_ready});
    end
  endtask

  task automatic test_loopback();
    logic [3:0] words [2];
    words[0] = 4'b1010;
    words[1] = 4'b0110;
    for (int w = 0; w < 2; w++) begin
      p_in = words[w]; p_valid = 1'b1;
      repeat (4) begin
        @(negedge clk);
        p_valid = 1'b0;
      end
      @(negedge clk);
      n_vec++;
      if (r_sipo !== words[w]) begin
        n_err++;
        $display("FAIL loopback word%0d: sipo=%b want %b", w, r_sipo, words[w]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mid_word_input();
    test_reset_mid_word();
    test_lsb_first();
    test_loopback();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_piso_tx
`default_nettype wire
